// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster generator. Four-phase horizontal and
//            vertical timing, configurable sync polarity, pixel clock-enable
//            and a latency-matched pixel request/return pipeline.
//            Optional build macro VGA_TEST_PATTERN_EN adds the pat_sel input
//            and an eight-bar colour test pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_LAT  = 1,
    parameter int CNT_W    = 10,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                   pat_sel,
`endif
    input  logic [R_W+G_W+B_W-1:0] pix_data,
    output logic                   req,
    output logic [CNT_W-1:0]       x,
    output logic [CNT_W-1:0]       y,
    output logic                   frame_start,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [R_W-1:0]         red,
    output logic [G_W-1:0]         green,
    output logic [B_W-1:0]         blue
);

    localparam int c_PIX_W   = R_W + G_W + B_W;
    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Comparison constants are one bit wider than the counters so that a
    // boundary equal to 2**CNT_W is still representable.
    localparam int c_HL_I  = c_H_TOTAL - 1;
    localparam int c_VL_I  = c_V_TOTAL - 1;
    localparam int c_HA_I  = H_ACTIVE;
    localparam int c_VA_I  = V_ACTIVE;
    localparam int c_HSB_I = H_ACTIVE + H_FP;
    localparam int c_HSE_I = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_VSB_I = V_ACTIVE + V_FP;
    localparam int c_VSE_I = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CNT_W:0] c_H_LAST = c_HL_I[CNT_W:0];
    localparam logic [CNT_W:0] c_V_LAST = c_VL_I[CNT_W:0];
    localparam logic [CNT_W:0] c_H_ACT  = c_HA_I[CNT_W:0];
    localparam logic [CNT_W:0] c_V_ACT  = c_VA_I[CNT_W:0];
    localparam logic [CNT_W:0] c_HS_BEG = c_HSB_I[CNT_W:0];
    localparam logic [CNT_W:0] c_HS_END = c_HSE_I[CNT_W:0];
    localparam logic [CNT_W:0] c_VS_BEG = c_VSB_I[CNT_W:0];
    localparam logic [CNT_W:0] c_VS_END = c_VSE_I[CNT_W:0];

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic c_HS_ON = (HS_POL != 0);
    localparam logic c_VS_ON = (VS_POL != 0);

`ifdef VGA_TEST_PATTERN_EN
    // Stage-0 bundle: {pat_sel, bar colour, act, hs0, vs0}
    localparam int c_SH_W = 4 + c_PIX_W;
`else
    // Stage-0 bundle: {act, hs0, vs0}
    localparam int c_SH_W = 3;
`endif

    logic [CNT_W-1:0]   r_hcnt;
    logic [CNT_W-1:0]   r_vcnt;
    logic [CNT_W:0]     w_h;
    logic [CNT_W:0]     w_v;
    logic               w_act;
    logic               w_hs0;
    logic               w_vs0;
    logic [c_SH_W-1:0]  w_st0;
    logic [c_SH_W-1:0]  w_st_d;
    logic               w_act_d;
    logic               w_hs_d;
    logic               w_vs_d;
    logic [c_PIX_W-1:0] w_pix;

    logic               r_de;
    logic               r_hs;
    logic               r_vs;
    logic [c_PIX_W-1:0] r_rgb;

    assign w_h = {1'b0, r_hcnt};
    assign w_v = {1'b0, r_vcnt};

    // Raster position counters: pixel counter wraps each line, line counter each frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (ce) begin
            if (w_h == c_H_LAST) begin
                r_hcnt <= '0;
                if (w_v == c_V_LAST) begin
                    r_vcnt <= '0;
                end else begin
                    r_vcnt <= r_vcnt + c_ONE;
                end
            end else begin
                r_hcnt <= r_hcnt + c_ONE;
            end
        end
    end

    // Stage-0 decode of the current raster position
    assign w_act = (w_h < c_H_ACT) && (w_v < c_V_ACT);
    assign w_hs0 = (w_h >= c_HS_BEG) && (w_h < c_HS_END);
    assign w_vs0 = (w_v >= c_VS_BEG) && (w_v < c_VS_END);

    assign req         = w_act;
    assign x           = r_hcnt;
    assign y           = r_vcnt;
    assign frame_start = (r_hcnt == '0) && (r_vcnt == '0);

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_SEG_I = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) - 1 : 0;
    localparam logic [CNT_W-1:0] c_SEG_LAST = c_SEG_I[CNT_W-1:0];

    logic [CNT_W-1:0]   r_bar_cnt;
    logic [2:0]         r_bar;
    logic [c_PIX_W-1:0] w_bar_rgb;
    logic               w_pat_d;
    logic [c_PIX_W-1:0] w_bar_d;

    // Bar index tracks hcnt: steps every H_ACTIVE/8 pixels, restarts with each line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bar_cnt <= '0;
            r_bar     <= 3'd0;
        end else if (ce) begin
            if (w_h == c_H_LAST) begin
                r_bar_cnt <= '0;
                r_bar     <= 3'd0;
            end else if (r_bar_cnt == c_SEG_LAST) begin
                r_bar_cnt <= '0;
                r_bar     <= r_bar + 3'd1;
            end else begin
                r_bar_cnt <= r_bar_cnt + c_ONE;
            end
        end
    end

    assign w_bar_rgb = {{R_W{r_bar[2]}}, {G_W{r_bar[1]}}, {B_W{r_bar[0]}}};
    assign w_st0     = {pat_sel, w_bar_rgb, w_act, w_hs0, w_vs0};
    assign w_pat_d   = w_st_d[c_SH_W-1];
    assign w_bar_d   = w_st_d[c_SH_W-2 -: c_PIX_W];
    assign w_pix     = w_pat_d ? w_bar_d : pix_data;
`else
    assign w_st0 = {w_act, w_hs0, w_vs0};
    assign w_pix = pix_data;
`endif

    assign w_act_d = w_st_d[2];
    assign w_hs_d  = w_st_d[1];
    assign w_vs_d  = w_st_d[0];

    generate
        if (PIX_LAT == 0) begin : g_lat0
            assign w_st_d = w_st0;
        end else begin : g_latn
            logic [c_SH_W-1:0] r_sh [PIX_LAT];

            // Delay line matching the pixel source latency; cleared to inactive on reset
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < PIX_LAT; i++) begin
                        r_sh[i] <= '0;
                    end
                end else if (ce) begin
                    r_sh[0] <= w_st0;
                    for (int i = 1; i < PIX_LAT; i++) begin
                        r_sh[i] <= r_sh[i-1];
                    end
                end
            end

            assign w_st_d = r_sh[PIX_LAT-1];
        end
    endgenerate

    // Output register: applies sync polarity and blanks colour outside the active area
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_de  <= 1'b0;
            r_hs  <= ~c_HS_ON;
            r_vs  <= ~c_VS_ON;
            r_rgb <= '0;
        end else if (ce) begin
            r_de  <= w_act_d;
            r_hs  <= w_hs_d ? c_HS_ON : ~c_HS_ON;
            r_vs  <= w_vs_d ? c_VS_ON : ~c_VS_ON;
            r_rgb <= w_act_d ? w_pix : '0;
        end
    end

    assign de    = r_de;
    assign hsync = r_hs;
    assign vsync = r_vs;
    assign red   = r_rgb[c_PIX_W-1 -: R_W];
    assign green = r_rgb[G_W+B_W-1 -: G_W];
    assign blue  = r_rgb[B_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench for vga_timing_gen using a small raster so
//            whole frames fit in a short run. A position-indexed reference
//            model is checked every cycle, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 3, HSY = 4, HBP = 5;
    localparam int VA = 6,  VFP = 2, VSY = 2, VBP = 3;
    localparam int H_TOT = HA + HFP + HSY + HBP;   // 28
    localparam int V_TOT = VA + VFP + VSY + VBP;   // 13
    localparam int LAT   = 2;
    localparam int HPOL  = 0;
    localparam int VPOL  = 1;
    localparam int CW    = 5;
`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          pat_sel = 1'b0;
    logic [7:0]    pix_data = 8'd0;
    logic          req;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          frame_start;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [2:0]    red;
    logic [2:0]    green;
    logic [1:0]    blue;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL), .PIX_LAT(LAT), .CNT_W(CW),
        .R_W(3), .G_W(3), .B_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
`ifdef VGA_TEST_PATTERN_EN
        .pat_sel(pat_sel),
`endif
        .pix_data(pix_data),
        .req(req),
        .x(x),
        .y(y),
        .frame_start(frame_start),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .red(red),
        .green(green),
        .blue(blue)
    );

    int tests = 0;
    int fails = 0;
    int k = 0;          // ce-cycles processed since reset release
    int kv = 0;         // k as seen by the most recent check
    bit src_mode = 1'b0;
    logic [7:0] pixbuf [8];
    logic       patbuf [8];
    logic [7:0] xh [8];

    // Reference raster model: position is plain arithmetic on the ce count
    function automatic int hc(int n); return n % H_TOT; endfunction
    function automatic int vc(int n); return (n / H_TOT) % V_TOT; endfunction
    function automatic bit m_act(int n); return (hc(n) < HA) && (vc(n) < VA); endfunction
    function automatic bit m_hs(int n);
        return (hc(n) >= HA + HFP) && (hc(n) < HA + HFP + HSY);
    endfunction
    function automatic bit m_vs(int n);
        return (vc(n) >= VA + VFP) && (vc(n) < VA + VFP + VSY);
    endfunction
    function automatic logic [7:0] m_bar(int n);
        int b;
        b = hc(n) / (HA / 8);
        return {b[2] ? 3'b111 : 3'b000, b[1] ? 3'b111 : 3'b000, b[0] ? 2'b11 : 2'b00};
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", nm, got, exp, k, $time);
        end
    endtask

    task automatic compare();
        int j;
        logic [7:0] er;
        bit ede, ehs, evs;
        chk("x", int'(x), hc(k));
        chk("y", int'(y), vc(k));
        chk("req", int'(req), int'(m_act(k)));
        chk("frame_start", int'(frame_start), int'(hc(k) == 0 && vc(k) == 0));
        if (k < LAT + 1) begin
            ede = 1'b0; ehs = 1'b0; evs = 1'b0; er = 8'd0;
        end else begin
            j   = k - LAT - 1;
            ede = m_act(j);
            ehs = m_hs(j);
            evs = m_vs(j);
            if (!ede)                        er = 8'd0;
            else if (PAT_EN && patbuf[j % 8]) er = m_bar(j);
            else                              er = pixbuf[(k - 1) % 8];
        end
        chk("de", int'(de), int'(ede));
        chk("hsync", int'(hsync), ehs ? HPOL : 1 - HPOL);
        chk("vsync", int'(vsync), evs ? VPOL : 1 - VPOL);
        chk("rgb", int'({red, green, blue}), int'(er));
    endtask

    // One clock: drive inputs on the falling edge, check, then advance the model
    task automatic step(input logic r, input logic c, input logic [7:0] p, input logic ps);
        @(negedge clk);
        xh[k % 8] = 8'(x);
        if (src_mode) p = (k >= LAT) ? xh[(k - LAT) % 8] : 8'd0;
        rst = r;
        ce = c;
        pix_data = p;
        pat_sel = ps;
        if (!r) k = 0;
        #1;
        compare();
        kv = k;
        if (r && c) begin
            pixbuf[k % 8] = p;
            patbuf[k % 8] = ps;
            k++;
        end
    endtask

    initial begin
        int n_hs, n_de, n_vs, n_fs, fall1, fall2, cyc;
        logic prev_hs;
        bit cev;
        int mode;

        for (int i = 0; i < 8; i++) begin
            pixbuf[i] = 8'd0; patbuf[i] = 1'b0; xh[i] = 8'd0;
        end

        // Reset values
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_rgb", int'({red, green, blue}), 0);

        // Free-running frame with a source returning x delayed by the pipeline latency
        src_mode = 1'b1;
        n_hs = 0; n_de = 0; n_vs = 0; n_fs = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b1, 8'd0, 1'b0);
            if (kv == 2)  chk("de_before_first", int'(de), 0);
            if (kv == 3)  chk("first_de", int'(de), 1);
            if (kv == 3)  chk("first_rgb", int'({red, green, blue}), 8'h00);
            if (kv == 8)  chk("pixel5_rgb", int'({red, green, blue}), 8'h05);
            if (kv == 21) chk("hs_before_edge", int'(hsync), 1);
            if (kv == 22) chk("hs_edge", int'(hsync), 0);
            if (kv >= 3 && kv < 3 + H_TOT * V_TOT) begin
                n_hs += (hsync == 1'b0) ? 1 : 0;
                n_de += (de == 1'b1) ? 1 : 0;
                n_vs += (vsync == 1'b1) ? 1 : 0;
            end
            if (kv >= 1 && kv < 1 + H_TOT * V_TOT) n_fs += frame_start ? 1 : 0;
        end
        src_mode = 1'b0;
        chk("hs_count_frame", n_hs, 52);
        chk("de_count_frame", n_de, 96);
        chk("vs_count_frame", n_vs, 56);
        chk("fs_count_frame", n_fs, 1);

        // Mid-line asynchronous reset
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("midrst_x", int'(x), 0);
        chk("midrst_hsync", int'(hsync), 1);
        chk("midrst_de", int'(de), 0);

        // ce at 1-of-2: hsync falling-edge period doubles to 56 clocks
        fall1 = -1; fall2 = -1; prev_hs = 1'b1; cev = 1'b1;
        for (cyc = 0; cyc < 300; cyc++) begin
            step(1'b1, cev, 8'($urandom_range(0, 255)), 1'b0);
            cev = ~cev;
            if (prev_hs && !hsync) begin
                if (fall1 < 0) fall1 = cyc;
                else if (fall2 < 0) fall2 = cyc;
            end
            prev_hs = hsync;
        end
        chk("hs_period_ce_half", (fall1 >= 0 && fall2 >= 0) ? fall2 - fall1 : 0, 56);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars: two pixels per bar on this raster
        step(1'b0, 1'b1, 8'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
            if (kv == 3)  chk("bar0", int'({red, green, blue}), 8'h00);
            if (kv == 5)  chk("bar1", int'({red, green, blue}), 8'h03);
            if (kv == 12) chk("bar4", int'({red, green, blue}), 8'hE0);
            if (kv == 18) chk("bar7", int'({red, green, blue}), 8'hFF);
        end
`endif

        // Randomized stimulus: ce patterns, pixel data, pattern select, sporadic resets
        mode = 0;
        for (int i = 0; i < 9000; i++) begin
            if (i % 500 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       cev = 1'b1;
                1:       cev = (i % 2 == 0);
                default: cev = ($urandom_range(0, 1) == 1);
            endcase
            if ($urandom_range(0, 999) == 0) begin
                for (int r = 0; r < int'($urandom_range(1, 3)); r++)
                    step(1'b0, cev, 8'($urandom_range(0, 255)), 1'b0);
            end
            step(1'b1, cev, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
